// File: rtl/laser_pkg.sv
// Shared constants, point type and loader state encoding for the LASER engine.
package laser_pkg;

    localparam int NUM_PTS   = 40;
    localparam int COORD_W   = 4;
    localparam int PT_ADDR_W = 6;
    localparam int GRID_DIM  = 16;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } loader_state_e;

endpackage

// File: rtl/laser_pt_regfile.sv
// Point storage for one frame: single write port plus a registered read port
// that returns zero for indices beyond the frame.
module laser_pt_regfile #(
    parameter int NUM_PTS = 40,
    parameter int COORD_W = 4,
    parameter int ADDR_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PTS - 1);

    logic [COORD_W-1:0] mem_x [NUM_PTS];
    logic [COORD_W-1:0] mem_y [NUM_PTS];
    logic [COORD_W-1:0] rd_x_q, rd_x_d;
    logic [COORD_W-1:0] rd_y_q, rd_y_d;

    // Storage is deliberately left out of reset; contents are rewritten before use.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= LAST_IDX)) begin
            mem_x[wr_addr] <= wr_x;
            mem_y[wr_addr] <= wr_y;
        end
    end

    always_comb begin
        rd_x_d = '0;
        rd_y_d = '0;
        if (rd_addr <= LAST_IDX) begin
            rd_x_d = mem_x[rd_addr];
            rd_y_d = mem_y[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_x_q <= '0;
            rd_y_q <= '0;
        end else begin
            rd_x_q <= rd_x_d;
            rd_y_q <= rd_y_d;
        end
    end

    assign rd_x = rd_x_q;
    assign rd_y = rd_y_q;

endmodule

// File: rtl/laser_point_loader.sv
// Frame loader for the LASER engine: collects NUM_PTS points, holds them until RELEASE.
// Optional occupancy bitmap enabled by defining LASER_OCCUPANCY_EN.
module laser_point_loader #(
    parameter int NUM_PTS = 40,
    parameter int COORD_W = 4,
    parameter int ADDR_W  = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    input  logic [COORD_W-1:0] X,
    input  logic [COORD_W-1:0] Y,
    output logic               IN_READY,
    output logic               FRAME_VALID,
    output logic [ADDR_W-1:0]  PT_CNT,
    input  logic [ADDR_W-1:0]  RD_ADDR,
    output logic [COORD_W-1:0] RD_X,
    output logic [COORD_W-1:0] RD_Y,
    input  logic               RELEASE,
    input  logic [COORD_W-1:0] ROW_SEL,
    output logic [15:0]        ROW_BITS
);

    import laser_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PTS - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              accept;
    logic              release_ok;

    // Counter stops at NUM_PTS because FULL never increments it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        release_ok = 1'b0;
        case (state_q)
            LOAD: begin
                if (IN_VALID && !RST) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (RELEASE) begin
                    release_ok = 1'b1;
                    cnt_d      = '0;
                    state_d    = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IN_READY    = (state_q == LOAD) && !RST;
    assign FRAME_VALID = (state_q == FULL);
    assign PT_CNT      = cnt_q;

    laser_pt_regfile #(
        .NUM_PTS (NUM_PTS),
        .COORD_W (COORD_W),
        .ADDR_W  (ADDR_W)
    ) u_regfile (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (accept),
        .wr_addr (cnt_q),
        .wr_x    (X),
        .wr_y    (Y),
        .rd_addr (RD_ADDR),
        .rd_x    (RD_X),
        .rd_y    (RD_Y)
    );

`ifdef LASER_OCCUPANCY_EN
    logic [GRID_DIM-1:0][GRID_DIM-1:0] occ_q, occ_d;
    logic [GRID_DIM-1:0]               row_bits_q, row_bits_d;

    // Row read samples the pre-update bitmap, so same-cycle writes are not visible yet.
    always_comb begin
        occ_d      = occ_q;
        row_bits_d = occ_q[ROW_SEL];
        if (release_ok) begin
            occ_d = '0;
        end else if (accept) begin
            occ_d[Y][X] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            occ_q      <= '0;
            row_bits_q <= '0;
        end else begin
            occ_q      <= occ_d;
            row_bits_q <= row_bits_d;
        end
    end

    assign ROW_BITS = row_bits_q;
`else
    logic unused_row_sel;

    assign unused_row_sel = ^ROW_SEL;
    assign ROW_BITS       = '0;
`endif

endmodule

// File: tb/tb_laser_point_loader.sv
// Directed self-checking bench for laser_point_loader (occupancy checks follow LASER_OCCUPANCY_EN).
module tb_laser_point_loader;

`ifdef LASER_OCCUPANCY_EN
    localparam bit OCC_ON = 1'b1;
`else
    localparam bit OCC_ON = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       IN_VALID;
    logic [3:0] X, Y;
    logic       IN_READY;
    logic       FRAME_VALID;
    logic [5:0] PT_CNT;
    logic [5:0] RD_ADDR;
    logic [3:0] RD_X, RD_Y;
    logic       RELEASE;
    logic [3:0] ROW_SEL;
    logic [15:0] ROW_BITS;

    int errors = 0;
    int checks = 0;
    int acc;

    laser_point_loader dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_VALID    (IN_VALID),
        .X           (X),
        .Y           (Y),
        .IN_READY    (IN_READY),
        .FRAME_VALID (FRAME_VALID),
        .PT_CNT      (PT_CNT),
        .RD_ADDR     (RD_ADDR),
        .RD_X        (RD_X),
        .RD_Y        (RD_Y),
        .RELEASE     (RELEASE),
        .ROW_SEL     (ROW_SEL),
        .ROW_BITS    (ROW_BITS)
    );

    always #5 CLK = ~CLK;

    // Advance one clock and settle 1ns past the rising edge.
    task automatic applyStimulus();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushPoint(input logic [3:0] px, input logic [3:0] py);
        IN_VALID = 1'b1;
        X = px;
        Y = py;
        applyStimulus();
        IN_VALID = 1'b0;
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; X = '0; Y = '0;
        RD_ADDR = '0; RELEASE = 1'b0; ROW_SEL = '0;

        // Reset state
        applyStimulus();
        checkOutput("rst_in_ready", 32'(IN_READY), 32'd0);
        checkOutput("rst_frame_valid", 32'(FRAME_VALID), 32'd0);
        checkOutput("rst_pt_cnt", 32'(PT_CNT), 32'd0);
        checkOutput("rst_rd_x", 32'(RD_X), 32'd0);
        checkOutput("rst_rd_y", 32'(RD_Y), 32'd0);
        checkOutput("rst_row_bits", 32'(ROW_BITS), 32'd0);
        RST = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(IN_READY), 32'd1);

        // Full frame of 40 back-to-back points
        for (int k = 0; k < 40; k++) begin
            checkOutput("load_in_ready", 32'(IN_READY), 32'd1);
            pushPoint(4'(k % 16), 4'(k / 16));
            checkOutput("load_frame_valid", 32'(FRAME_VALID), 32'(k == 39));
            checkOutput("load_pt_cnt", 32'(PT_CNT), 32'(k + 1));
        end
        checkOutput("full_in_ready", 32'(IN_READY), 32'd0);

        // Read port, latency 1, out-of-range zero
        RD_ADDR = 6'd0;  applyStimulus();
        checkOutput("rd0_x", 32'(RD_X), 32'd0);
        checkOutput("rd0_y", 32'(RD_Y), 32'd0);
        RD_ADDR = 6'd17; applyStimulus();
        checkOutput("rd17_x", 32'(RD_X), 32'd1);
        checkOutput("rd17_y", 32'(RD_Y), 32'd1);
        RD_ADDR = 6'd39; applyStimulus();
        checkOutput("rd39_x", 32'(RD_X), 32'd7);
        checkOutput("rd39_y", 32'(RD_Y), 32'd2);
        RD_ADDR = 6'd45; applyStimulus();
        checkOutput("rd45_x", 32'(RD_X), 32'd0);
        checkOutput("rd45_y", 32'(RD_Y), 32'd0);

        // IN_VALID held while FULL is dropped
        IN_VALID = 1'b1; X = 4'd3; Y = 4'd3;
        for (int c = 0; c < 5; c++) begin
            applyStimulus();
            checkOutput("full_hold_pt_cnt", 32'(PT_CNT), 32'd40);
            checkOutput("full_hold_frame_valid", 32'(FRAME_VALID), 32'd1);
        end

        // RELEASE beats a same-cycle point
        RELEASE = 1'b1; X = 4'd9; Y = 4'd9;
        applyStimulus();
        RELEASE = 1'b0;
        checkOutput("rel_pt_cnt", 32'(PT_CNT), 32'd0);
        checkOutput("rel_frame_valid", 32'(FRAME_VALID), 32'd0);
        checkOutput("rel_in_ready", 32'(IN_READY), 32'd1);
        X = 4'd5; Y = 4'd6;
        applyStimulus();
        IN_VALID = 1'b0;
        checkOutput("first_after_rel_pt_cnt", 32'(PT_CNT), 32'd1);
        RD_ADDR = 6'd0; applyStimulus();
        checkOutput("entry0_x", 32'(RD_X), 32'd5);
        checkOutput("entry0_y", 32'(RD_Y), 32'd6);

        // Read-before-write on entry 1
        RD_ADDR = 6'd1;
        pushPoint(4'd12, 4'd13);
        checkOutput("rbw_old_x", 32'(RD_X), 32'd1);
        checkOutput("rbw_old_y", 32'(RD_Y), 32'd0);
        checkOutput("rbw_pt_cnt", 32'(PT_CNT), 32'd2);
        applyStimulus();
        checkOutput("rbw_new_x", 32'(RD_X), 32'd12);
        checkOutput("rbw_new_y", 32'(RD_Y), 32'd13);

        // Partial frame then reset mid-load
        for (int k = 0; k < 10; k++) pushPoint(4'(k), 4'd0);
        checkOutput("partial_pt_cnt", 32'(PT_CNT), 32'd12);
        RST = 1'b1;
        applyStimulus();
        checkOutput("midrst_in_ready", 32'(IN_READY), 32'd0);
        checkOutput("midrst_pt_cnt", 32'(PT_CNT), 32'd0);
        RST = 1'b0;
        #1;
        for (int k = 0; k < 40; k++) begin
            RELEASE = (k == 20);
            pushPoint(4'(15 - (k % 16)), 4'((k / 16) + 4));
            checkOutput("reload_frame_valid", 32'(FRAME_VALID), 32'(k == 39));
            checkOutput("reload_pt_cnt", 32'(PT_CNT), 32'(k + 1));
        end
        RELEASE = 1'b0;
        RD_ADDR = 6'd0; applyStimulus();
        checkOutput("reload_e0_x", 32'(RD_X), 32'd15);
        checkOutput("reload_e0_y", 32'(RD_Y), 32'd4);
        RD_ADDR = 6'd39; applyStimulus();
        checkOutput("reload_e39_x", 32'(RD_X), 32'd8);
        checkOutput("reload_e39_y", 32'(RD_Y), 32'd6);

        // Gapped input across 80 cycles
        RELEASE = 1'b1; applyStimulus(); RELEASE = 1'b0;
        acc = 0;
        for (int i = 0; i < 80; i++) begin
            IN_VALID = (i % 2 == 0);
            X = 4'(i % 16);
            Y = 4'(i / 16);
            if (IN_VALID && acc < 40) acc++;
            applyStimulus();
            checkOutput("gap_pt_cnt", 32'(PT_CNT), 32'(acc));
            checkOutput("gap_frame_valid", 32'(FRAME_VALID), 32'(acc == 40));
        end
        IN_VALID = 1'b0;
        RD_ADDR = 6'd1; applyStimulus();
        checkOutput("gap_e1_x", 32'(RD_X), 32'd2);
        checkOutput("gap_e1_y", 32'(RD_Y), 32'd0);
        RD_ADDR = 6'd39; applyStimulus();
        checkOutput("gap_e39_x", 32'(RD_X), 32'd14);
        checkOutput("gap_e39_y", 32'(RD_Y), 32'd4);

        // Occupancy bitmap
        RELEASE = 1'b1; applyStimulus(); RELEASE = 1'b0;
        pushPoint(4'd11, 4'd0);
        pushPoint(4'd2, 4'd1);
        pushPoint(4'd10, 4'd1);
        pushPoint(4'd2, 4'd1);
        ROW_SEL = 4'd1; applyStimulus();
        checkOutput("occ_row1", 32'(ROW_BITS), OCC_ON ? 32'h0404 : 32'h0);
        ROW_SEL = 4'd0; applyStimulus();
        checkOutput("occ_row0", 32'(ROW_BITS), OCC_ON ? 32'h0800 : 32'h0);
        ROW_SEL = 4'd1;
        pushPoint(4'd3, 4'd1);
        checkOutput("occ_rbw_old", 32'(ROW_BITS), OCC_ON ? 32'h0404 : 32'h0);
        applyStimulus();
        checkOutput("occ_rbw_new", 32'(ROW_BITS), OCC_ON ? 32'h040C : 32'h0);
        for (int k = 0; k < 35; k++) pushPoint(4'(k % 16), 4'd15);
        checkOutput("occ_frame_valid", 32'(FRAME_VALID), 32'd1);
        ROW_SEL = 4'd15; applyStimulus();
        checkOutput("occ_row15", 32'(ROW_BITS), OCC_ON ? 32'hFFFF : 32'h0);
        RELEASE = 1'b1; applyStimulus(); RELEASE = 1'b0;
        for (int r = 0; r < 16; r++) begin
            ROW_SEL = 4'(r);
            applyStimulus();
            checkOutput("occ_cleared", 32'(ROW_BITS), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
